bcd_updown_multidigit_counter: RTL
==================================

Name: bcd_updown_multidigit_counter

Overview:
Parametrised multi-digit BCD up/down counter, the successor to the single-digit decade up/down counter. It chains DIGITS decade stages with ripple carry and borrow, and adds count-enable, synchronous parallel load, selectable wrap or saturate at the limits, and a terminal-count pulse. It is intended for display/timer front-ends and event counters that need decimal readout without a binary-to-BCD converter.

Parameters:
DIGITS, 4, number of cascaded BCD digits (1..8); counter range 0 .. 10^DIGITS-1
WRAP, 1, 1 = wrap at limits (max->0 up, 0->max down); 0 = saturate (hold at limit)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
en  input  1  count enable; one step per cycle while high
sel  input  1  direction: 0 = up, 1 = down
load  input  1  synchronous parallel load strobe
load_val  input  4*DIGITS  BCD load value; digit i at bits [4i+3:4i]
count  output  4*DIGITS  registered BCD count; digit 0 = least significant
tc  output  1  registered one-cycle terminal-count pulse
at_max  output  1  combinational; count == all digits 9
at_min  output  1  combinational; count == all digits 0

Behaviour:
- One clock (clk). Reset is synchronous and active-high: sampled only on the rising edge of clk.
- Reset values: count = 0, tc = 0. at_max = 0 and at_min = 1 follow from count.
- Priority per rising edge: reset > load > en. Lower-priority actions are ignored in that cycle.
- Load: count <= load_val, applied per digit. Any digit > 9 is clamped to 9, so count never holds a non-BCD digit. tc <= 0. Load is independent of en and sel.
- en = 0 (and no load/reset): count holds and tc <= 0.
- Up step (en = 1, sel = 0):
  - Digit 0 increments.
  - Digit i > 0 increments only when all lower digits equal 9; each digit that was 9 and receives a carry becomes 0.
- Down step (en = 1, sel = 1):
  - Digit 0 decrements.
  - Digit i > 0 decrements only when all lower digits equal 0; each digit that was 0 and receives a borrow becomes 9.
- Up from all-9s:
  - WRAP = 1: count <= 0 and tc <= 1.
  - WRAP = 0: count holds all-9s and tc <= 1.
- Down from all-0s:
  - WRAP = 1: count <= all-9s and tc <= 1.
  - WRAP = 0: count holds 0 and tc <= 1.
- tc otherwise:
  - 0 on every cycle with no wrap or blocked step.
  - Latency: tc is high in the same cycle the new (wrapped or held) count becomes visible, for one cycle per event.
  - Saturated with en held high toward the limit (WRAP = 0): tc stays high every cycle.
- Direction change mid-count takes effect on the next enabled edge. There is no extra latency and no skipped value.
- Reset or load asserted on the same edge as a wrap: the wrap is suppressed and tc = 0.
- All count logic is a single always block on the rising edge of clk. Carry/borrow chain is combinational from the current count; no multi-cycle ripple.

Test Plan:
- DIGITS=2, WRAP=1: reset, en=1, sel=0 for 100 cycles -> count 00,01..09,10..99,00. tc high only on the cycle count shows 00 after 99.
- DIGITS=2, WRAP=1: load 0x10, then en=1, sel=1 for 3 cycles -> 09, 08, 07. Load 0x00, one down step -> 99 with tc=1.
- DIGITS=2, WRAP=0: load 0x98, en=1, sel=0 for 4 cycles -> 99, 99, 99, 99. tc = 0,1,1,1 and at_max = 1 from cycle 1. Then sel=1 -> 98, tc=0.
- DIGITS=2: load_val = 0xAF -> count 0x99. load_val = 0x3C -> count 0x39.
- DIGITS=2: count 0x99 up with load=1 (load_val = 0x42) on the same edge -> 0x42, tc=0. Count 0x57 with en=0 for 5 cycles -> holds 0x57.
- DIGITS=4: count 0x0999, en=1, sel=0 with reset=1 on the same edge -> 0x0000, tc=0. Next edge with reset=0 -> 0x0001.

Source files
------------

// File: rtl/bcd_updown_multidigit_counter.sv
// ---------------------------------------------------------------------------
// bcd_updown_multidigit_counter
//
// Multi-digit BCD up/down counter built from DIGITS cascaded decade stages.
// It supports a count enable, a synchronous parallel load that clamps
// non-BCD digits to 9, wrap-or-saturate at the limits, and a registered
// one-cycle terminal-count pulse.
//
// Parameters:
//   DIGITS   number of BCD digits (1..8); range 0 .. 10^DIGITS-1
//   WRAP     1 = wrap at the limits, 0 = saturate (hold at the limit)
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset
//   en        in   count enable, one step per cycle while high
//   sel       in   direction: 0 = up, 1 = down
//   load      in   synchronous parallel load strobe (beats en)
//   load_val  in   BCD load value, digit i at bits [4i+3:4i]
//   count     out  registered BCD count, digit 0 least significant
//   tc        out  registered terminal-count pulse (wrap or blocked step)
//   at_max    out  combinational, count is all 9s
//   at_min    out  combinational, count is all 0s
// ---------------------------------------------------------------------------
module bcd_updown_multidigit_counter #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  sel,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  at_max,
    output logic                  at_min
);

    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic [4*DIGITS-1:0] up_val;
    logic [4*DIGITS-1:0] down_val;
    logic [4*DIGITS-1:0] load_clamped;
    logic                carry;
    logic                borrow;
    logic [3:0]          digit;
    logic [3:0]          ld_digit;

    assign at_max = (count == ALL_NINES);
    assign at_min = (count == '0);

    // Carry and borrow ripple through the digits within one cycle. Each
    // stage steps only when every lower stage is at its limit.
    always_comb begin
        // NOTE: every variable gets a default first and is then updated with
        // blocking assignments, so carry/borrow flow stage to stage within
        // this pass and no latch can be inferred.
        up_val       = '0;
        down_val     = '0;
        load_clamped = '0;
        carry        = 1'b1;
        borrow       = 1'b1;
        digit        = '0;
        ld_digit     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = count[4*i +: 4];

            if (carry) begin
                up_val[4*i +: 4] = (digit >= 4'd9) ? 4'd0 : digit + 4'd1;
            end else begin
                up_val[4*i +: 4] = digit;
            end
            carry = carry && (digit >= 4'd9);

            if (borrow) begin
                down_val[4*i +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
            end else begin
                down_val[4*i +: 4] = digit;
            end
            borrow = borrow && (digit == 4'd0);

            // Out-of-range load digits are clamped so count stays pure BCD.
            ld_digit = load_val[4*i +: 4];
            load_clamped[4*i +: 4] = (ld_digit > 4'd9) ? 4'd9 : ld_digit;
        end
    end

    // Priority: reset > load > en. A step past a limit raises tc and either
    // wraps or holds, depending on WRAP.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, and the
        // reset here is sampled on the clock edge rather than asynchronously.
        if (reset) begin
            count <= '0;
            tc    <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            tc    <= 1'b0;
        end else if (en && !sel) begin
            if (at_max) begin
                tc <= 1'b1;
                if (WRAP) begin
                    count <= '0;
                end
            end else begin
                count <= up_val;
                tc    <= 1'b0;
            end
        end else if (en && sel) begin
            if (at_min) begin
                tc <= 1'b1;
                if (WRAP) begin
                    count <= ALL_NINES;
                end
            end else begin
                count <= down_val;
                tc    <= 1'b0;
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule
